// File: rtl/key_event_decoder.sv
// Debounces press and release of one raw mechanical key and classifies the
// gesture into registered one-cycle press/release/short/long/repeat pulses.
module key_event_decoder #(
  parameter int DEBOUNCE_CYC = 25000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DBC_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             key_meta, ks;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] dbc, dbc_nxt, hold, hold_nxt;
  logic             was_long, was_long_nxt;
  logic             level_nxt, press_nxt, release_nxt, short_nxt, long_nxt, repeat_nxt;
  logic             tick_long, tick_rep;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) is reserved for the combinational block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b0;
      ks       <= 1'b0;
    end else begin
      key_meta <= key;
      ks       <= key_meta;
    end
  end

  // NOTE: every register, outputs included, is cleared by the async reset so
  // a reset mid-gesture can never leave a stale pulse or level behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dbc           <= '0;
      hold          <= '0;
      was_long      <= 1'b0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nxt;
      dbc           <= dbc_nxt;
      hold          <= hold_nxt;
      was_long      <= was_long_nxt;
      key_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      short_pulse   <= short_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

  // NOTE: all outputs of this block get a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    dbc_nxt      = dbc;
    hold_nxt     = hold;
    was_long_nxt = was_long;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    short_nxt    = 1'b0;
    long_nxt     = 1'b0;
    repeat_nxt   = 1'b0;
    tick_long    = 1'b0;
    tick_rep     = 1'b0;

    case (state)
      IDLE: begin
        if (ks) begin
          state_nxt = PRESS_WAIT;
          dbc_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!ks) begin
          state_nxt = IDLE;
          dbc_nxt   = '0;
        end else if (dbc == DBC_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          hold_nxt  = '0;
          dbc_nxt   = '0;
        end else begin
          dbc_nxt = dbc + CNT_ONE;
        end
      end
      HELD, LONG_HELD: begin
        if (!ks) begin
          state_nxt = RELEASE_WAIT;
          dbc_nxt   = CNT_ONE;
        end else if (state == HELD) begin
          tick_long = 1'b1;
        end else begin
          tick_rep = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A returning high counts as a held cycle, so a glitch delays the
        // hold timing by exactly its own length.
        if (ks) begin
          dbc_nxt   = '0;
          tick_rep  = was_long;
          tick_long = !was_long;
        end else if (dbc == DBC_LAST) begin
          state_nxt    = IDLE;
          release_nxt  = 1'b1;
          short_nxt    = !was_long;
          was_long_nxt = 1'b0;
          dbc_nxt      = '0;
        end else begin
          dbc_nxt = dbc + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tick_long) begin
      if (hold == LONG_LAST) begin
        state_nxt    = LONG_HELD;
        long_nxt     = 1'b1;
        hold_nxt     = '0;
        was_long_nxt = 1'b1;
      end else begin
        state_nxt = HELD;
        hold_nxt  = hold + CNT_ONE;
      end
    end

    if (tick_rep) begin
      state_nxt = LONG_HELD;
      if (hold == REP_LAST) begin
        repeat_nxt = 1'b1;
        hold_nxt   = '0;
      end else begin
        hold_nxt = hold + CNT_ONE;
      end
    end

    level_nxt = (state_nxt == HELD) || (state_nxt == LONG_HELD) ||
                (state_nxt == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short thresholds; a negedge
// monitor logs pulse counts/times and protocol violations for the checks.
module tb_key_event_decoder;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset;
  logic key;
  logic key_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int n_press = 0, n_release = 0, n_short = 0, n_long = 0, n_rep = 0, n_level = 0, n_viol = 0;
  int t_press = -1, t_release = -1, t_short = -1, t_long = -1, t_rep = -1;
  logic pressed = 1'b0;
  logic [4:0] prev_pulses = '0;

  key_event_decoder #(
    .DEBOUNCE_CYC(D),
    .LONG_CYC    (L),
    .REPEAT_CYC  (R),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [4:0] pulses;
    pulses = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
    if (reset) begin
      pressed     = 1'b0;
      prev_pulses = '0;
    end else begin
      if (press_pulse) begin
        n_press++; t_press = cyc;
        if (pressed || !key_level) n_viol++;
        pressed = 1'b1;
      end
      if (release_pulse) begin
        n_release++; t_release = cyc;
        if (!pressed || key_level) n_viol++;
        pressed = 1'b0;
      end
      if (short_pulse) begin
        n_short++; t_short = cyc;
        if (!release_pulse) n_viol++;
      end
      if (long_pulse)   begin n_long++; t_long = cyc; end
      if (repeat_pulse) begin n_rep++;  t_rep  = cyc; end
      if (key_level) n_level++;
      if ($countones({press_pulse, release_pulse | short_pulse, long_pulse, repeat_pulse}) > 1)
        n_viol++;
      if ((pulses & prev_pulses) != 5'b0) n_viol++;
      prev_pulses = pulses;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bounce(input logic final_val);
    for (int i = 0; i < 4; i++) begin
      key = ~key;
      step(int'($urandom_range(1, 3)));
    end
    key = final_val;
  endtask

  initial begin
    int t0, r, bp, br, bs, bl, brp, blv;
    reset = 1'b1;
    key   = 1'b0;
    step(3);
    check("reset_level", int'(key_level), 0);
    check("reset_pulses", int'({press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse}), 0);
    reset = 1'b0;
    step(3);

    // 1: three-cycle blip is a glitch
    bp = n_press; blv = n_level; br = n_release;
    t0 = cyc; key = 1'b1; step(3); key = 1'b0; step(15);
    check("t1_no_press", n_press - bp, 0);
    check("t1_no_release", n_release - br, 0);
    check("t1_level_low", n_level - blv, 0);

    // 1b: four cycles is just enough to be accepted
    bp = n_press; bs = n_short;
    t0 = cyc; key = 1'b1; step(4); key = 1'b0; step(15);
    check("t1b_press_cnt", n_press - bp, 1);
    check("t1b_press_time", t_press, t0 + 6);
    check("t1b_release_time", t_release, t0 + 10);
    check("t1b_short_cnt", n_short - bs, 1);

    // 2: short press
    bp = n_press; br = n_release; bs = n_short; blv = n_level; bl = n_long;
    t0 = cyc; key = 1'b1; step(10); key = 1'b0; step(15);
    check("t2_press_cnt", n_press - bp, 1);
    check("t2_press_time", t_press, t0 + 6);
    check("t2_release_cnt", n_release - br, 1);
    check("t2_release_time", t_release, t0 + 16);
    check("t2_short_time", t_short, t0 + 16);
    check("t2_short_cnt", n_short - bs, 1);
    check("t2_level_cycles", n_level - blv, 10);
    check("t2_no_long", n_long - bl, 0);

    // 3: long press with two repeats
    bp = n_press; bs = n_short; bl = n_long; brp = n_rep; br = n_release;
    t0 = cyc; key = 1'b1; step(46); key = 1'b0; step(15);
    check("t3_press_time", t_press, t0 + 6);
    check("t3_long_cnt", n_long - bl, 1);
    check("t3_long_time", t_long, t0 + 26);
    check("t3_rep_cnt", n_rep - brp, 2);
    check("t3_rep_last", t_rep, t0 + 42);
    check("t3_release_time", t_release, t0 + 52);
    check("t3_release_cnt", n_release - br, 1);
    check("t3_no_short", n_short - bs, 0);

    // 4: release glitches of 1+2+3 cycles delay long by 6
    bp = n_press; br = n_release; bl = n_long; brp = n_rep;
    t0 = cyc; key = 1'b1;
    step(10); key = 1'b0; step(1); key = 1'b1;
    step(4);  key = 1'b0; step(2); key = 1'b1;
    step(3);  key = 1'b0; step(3); key = 1'b1;
    step(17); key = 1'b0; step(15);
    check("t4_press_cnt", n_press - bp, 1);
    check("t4_release_cnt", n_release - br, 1);
    check("t4_long_time", t_long, t0 + 32);
    check("t4_rep_cnt", n_rep - brp, 1);
    check("t4_release_time", t_release, t0 + 46);

    // 5: async reset mid-HELD with key still high
    bp = n_press; br = n_release; bs = n_short;
    t0 = cyc; key = 1'b1; step(12);
    #2 reset = 1'b1;
    #1;
    check("t5_level_async", int'(key_level), 0);
    check("t5_pulses_async", int'({press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse}), 0);
    step(2);
    reset = 1'b0; r = cyc;
    step(10);
    check("t5_press_cnt", n_press - bp, 2);
    check("t5_repress_time", t_press, r + 6);
    check("t5_no_release", n_release - br, 0);
    check("t5_no_short", n_short - bs, 0);
    key = 1'b0; step(15);

    // 6: bouncy edges on both press and release
    bp = n_press; br = n_release;
    for (int g = 0; g < 4; g++) begin
      bounce(1'b1); step(14);
      bounce(1'b0); step(14);
    end
    check("t6_press_cnt", n_press - bp, 4);
    check("t6_release_cnt", n_release - br, 4);
    check("protocol_violations", n_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
